// File: rtl/vxe_vpu_disp_if.sv
// Command-side and unit-side signal bundle for the VPU command dispatcher.
// The slave modport is the dispatcher's view. The master modport is the view of
// whoever drives commands in and done pulses back (a command source plus the
// three execution units).
interface vxe_vpu_disp_if;
    // Command input handshake
    logic        i_vld;
    logic        o_rdy;
    logic [4:0]  i_cmd_op;
    logic [2:0]  i_cmd_th;
    logic [47:0] i_cmd_pl;

    // Shared registered command bus towards the execution units
    logic [4:0]  o_cmd_op;
    logic [2:0]  o_cmd_th;
    logic [47:0] o_cmd_pl;

    // Per-unit dispatch pulses, completion pulses and write-port ownership
    logic        o_regu_disp;
    logic        o_prod_disp;
    logic        o_actf_disp;
    logic        i_regu_done;
    logic        i_prod_done;
    logic        i_actf_done;
    logic        o_regu_cmd;
    logic        o_prod_cmd;
    logic        o_actf_cmd;

    // Status
    logic        o_err;
    logic        o_idle;

    modport slave (
        input  i_vld, i_cmd_op, i_cmd_th, i_cmd_pl,
        input  i_regu_done, i_prod_done, i_actf_done,
        output o_rdy, o_cmd_op, o_cmd_th, o_cmd_pl,
        output o_regu_disp, o_prod_disp, o_actf_disp,
        output o_regu_cmd, o_prod_cmd, o_actf_cmd,
        output o_err, o_idle
    );

    modport master (
        output i_vld, i_cmd_op, i_cmd_th, i_cmd_pl,
        output i_regu_done, i_prod_done, i_actf_done,
        input  o_rdy, o_cmd_op, o_cmd_th, o_cmd_pl,
        input  o_regu_disp, o_prod_disp, o_actf_disp,
        input  o_regu_cmd, o_prod_cmd, o_actf_cmd,
        input  o_err, o_idle
    );
endinterface

// File: rtl/vxe_vpu_disp.sv
// VPU command dispatcher.
// Accepts one command at a time into a single-entry hold register and decodes
// the opcode. It issues the command to regu, prod or actf with a one-cycle
// dispatch pulse on a shared registered command bus, then tracks each unit as
// BUSY until that unit reports done. Dispatch is strictly in order: a blocked
// head entry stalls everything behind it. Unsupported opcodes are dropped and
// flagged with a one-cycle o_err pulse.
// Optional feature macro: VXE_VPU_DISP_TH_HAZARD_EN. When it is defined, a
// command whose thread is owned by any BUSY unit waits in hold until that unit
// finishes.
module vxe_vpu_disp (
    input  logic            clk,
    input  logic            nrst,
    vxe_vpu_disp_if.slave   bus
);

    // CU_CMD_* opcode encoding
    localparam logic [4:0] CU_CMD_SETACC = 5'd1;
    localparam logic [4:0] CU_CMD_SETVL  = 5'd2;
    localparam logic [4:0] CU_CMD_SETEN  = 5'd3;
    localparam logic [4:0] CU_CMD_SETRS  = 5'd4;
    localparam logic [4:0] CU_CMD_SETRT  = 5'd5;
    localparam logic [4:0] CU_CMD_SETRD  = 5'd6;
    localparam logic [4:0] CU_CMD_PROD   = 5'd8;
    localparam logic [4:0] CU_CMD_ACTF   = 5'd9;

    // Unit indices into the per-unit vectors
    localparam int U_REGU    = 0;
    localparam int U_PROD    = 1;
    localparam int U_ACTF    = 2;
    localparam int NUM_UNITS = 3;

    typedef enum logic {
        UNIT_IDLE = 1'b0,
        UNIT_BUSY = 1'b1
    } unit_state_t;

    // Hold register
    logic        hold_vld_reg;
    logic [4:0]  hold_op_reg;
    logic [2:0]  hold_th_reg;
    logic [47:0] hold_pl_reg;

    // Shared command bus
    logic [4:0]  cmd_op_reg;
    logic [2:0]  cmd_th_reg;
    logic [47:0] cmd_pl_reg;

    logic        err_reg;

    // Decode and issue control
    logic [NUM_UNITS-1:0] hold_tgt;
    logic                 hold_sup;
    logic [NUM_UNITS-1:0] unit_busy;
    logic [NUM_UNITS-1:0] unit_done;
    logic [NUM_UNITS-1:0] unit_disp;
    logic [NUM_UNITS-1:0] issue_vec;
    logic [7:0]           th_busy;
    logic                 unit_free;
    logic                 issue;
    logic                 discard;
    logic                 rdy;
    logic                 accept;

    assign unit_done[U_REGU] = bus.i_regu_done;
    assign unit_done[U_PROD] = bus.i_prod_done;
    assign unit_done[U_ACTF] = bus.i_actf_done;

    // Map the held opcode to the one-hot owning unit; zero means unsupported
    always_comb begin
        hold_tgt = '0;
        case (hold_op_reg)
            CU_CMD_SETACC,
            CU_CMD_SETVL,
            CU_CMD_SETEN,
            CU_CMD_SETRS,
            CU_CMD_SETRT,
            CU_CMD_SETRD: hold_tgt[U_REGU] = 1'b1;
            CU_CMD_PROD:  hold_tgt[U_PROD] = 1'b1;
            CU_CMD_ACTF:  hold_tgt[U_ACTF] = 1'b1;
            default:      hold_tgt = '0;
        endcase
    end

    assign hold_sup  = |hold_tgt;
    assign unit_free = |(hold_tgt & ~unit_busy);

    // The head entry leaves the hold register on an issue or a discard edge.
    // Only an issue re-opens the input in the same cycle; a discarded entry
    // frees the slot one edge later.
    assign issue     = hold_vld_reg & hold_sup & unit_free & ~th_busy[hold_th_reg];
    assign discard   = hold_vld_reg & ~hold_sup;
    assign issue_vec = hold_tgt & {NUM_UNITS{issue}};
    assign rdy       = ~hold_vld_reg | issue;
    assign accept    = bus.i_vld & rdy;

    // Hold register: a capture wins over the clear from the departing entry
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold_vld_reg <= 1'b0;
            hold_op_reg  <= '0;
            hold_th_reg  <= '0;
            hold_pl_reg  <= '0;
        end else if (accept) begin
            hold_vld_reg <= 1'b1;
            hold_op_reg  <= bus.i_cmd_op;
            hold_th_reg  <= bus.i_cmd_th;
            hold_pl_reg  <= bus.i_cmd_pl;
        end else if (issue || discard) begin
            hold_vld_reg <= 1'b0;
        end
    end

    // Per-unit busy tracking, dispatch pulse and (optionally) owner thread
    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            unit_state_t state_reg;
            unit_state_t state_next;
            logic        disp_reg;

            // Unit FSM state register
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    state_reg <= UNIT_IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Unit FSM next state: an issue makes the unit busy and a done frees it.
            // A done pulse while the unit is idle is ignored.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    UNIT_IDLE: if (issue_vec[gi]) state_next = UNIT_BUSY;
                    UNIT_BUSY: if (unit_done[gi]) state_next = UNIT_IDLE;
                    default:   state_next = UNIT_IDLE;
                endcase
            end

            // Dispatch pulse, high for exactly the cycle after the issue edge
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    disp_reg <= 1'b0;
                end else begin
                    disp_reg <= issue_vec[gi];
                end
            end

            assign unit_busy[gi] = (state_reg == UNIT_BUSY);
            assign unit_disp[gi] = disp_reg;

`ifdef VXE_VPU_DISP_TH_HAZARD_EN
            logic [2:0] unit_th_reg;
            logic [7:0] th_mask;

            // Remember which thread the unit is working for
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    unit_th_reg <= '0;
                end else if (issue_vec[gi]) begin
                    unit_th_reg <= hold_th_reg;
                end
            end

            assign th_mask = unit_busy[gi] ? (8'b1 << unit_th_reg) : 8'b0;
`endif
        end
    endgenerate

`ifdef VXE_VPU_DISP_TH_HAZARD_EN
    // Threads currently owned by any busy unit
    always_comb begin
        th_busy = g_unit[U_REGU].th_mask
                | g_unit[U_PROD].th_mask
                | g_unit[U_ACTF].th_mask;
    end
`else
    assign th_busy = 8'b0;
`endif

    // Shared command bus: loaded only on an issue edge, so it stays stable
    // through the dispatch cycle of the unit that consumes it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cmd_op_reg <= '0;
            cmd_th_reg <= '0;
            cmd_pl_reg <= '0;
        end else if (issue) begin
            cmd_op_reg <= hold_op_reg;
            cmd_th_reg <= hold_th_reg;
            cmd_pl_reg <= hold_pl_reg;
        end
    end

    // One-cycle error pulse for each discarded unsupported command
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= discard;
        end
    end

    assign bus.o_rdy       = rdy;
    assign bus.o_cmd_op    = cmd_op_reg;
    assign bus.o_cmd_th    = cmd_th_reg;
    assign bus.o_cmd_pl    = cmd_pl_reg;
    assign bus.o_regu_disp = unit_disp[U_REGU];
    assign bus.o_prod_disp = unit_disp[U_PROD];
    assign bus.o_actf_disp = unit_disp[U_ACTF];
    assign bus.o_regu_cmd  = unit_busy[U_REGU];
    assign bus.o_prod_cmd  = unit_busy[U_PROD];
    assign bus.o_actf_cmd  = unit_busy[U_ACTF];
    assign bus.o_err       = err_reg;
    assign bus.o_idle      = ~hold_vld_reg & ~(|unit_busy);

endmodule

// File: tb/tb_vxe_vpu_disp.sv
// Directed testbench for vxe_vpu_disp. Inputs are driven 1 ns after each
// rising edge and outputs are checked at that point, away from the edge.
module tb_vxe_vpu_disp;

    localparam logic [4:0] OP_SETACC = 5'd1;
    localparam logic [4:0] OP_SETVL  = 5'd2;
    localparam logic [4:0] OP_SETEN  = 5'd3;
    localparam logic [4:0] OP_SETRS  = 5'd4;
    localparam logic [4:0] OP_SETRD  = 5'd6;
    localparam logic [4:0] OP_PROD   = 5'd8;
    localparam logic [4:0] OP_ACTF   = 5'd9;
    localparam logic [4:0] OP_STORE  = 5'd12;

    logic clk;
    logic nrst;
    int   n_assert;
    int   n_fail;

    vxe_vpu_disp_if bus_if ();

    vxe_vpu_disp dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_cmd(input logic [4:0] op, input logic [2:0] th, input logic [47:0] pl);
        bus_if.i_vld    = 1'b1;
        bus_if.i_cmd_op = op;
        bus_if.i_cmd_th = th;
        bus_if.i_cmd_pl = pl;
        $display("cmd op=%0d th=%0d pl=%012h at %0t", op, th, pl, $time);
    endtask

    task automatic idle_cmd();
        bus_if.i_vld    = 1'b0;
        bus_if.i_cmd_op = '0;
        bus_if.i_cmd_th = '0;
        bus_if.i_cmd_pl = '0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        idle_cmd();
        bus_if.i_regu_done = 1'b0;
        bus_if.i_prod_done = 1'b0;
        bus_if.i_actf_done = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_rdy",  bus_if.o_rdy, 1);
        chk("rst_idle", bus_if.o_idle, 1);
        chk("rst_disp", {bus_if.o_regu_disp, bus_if.o_prod_disp, bus_if.o_actf_disp}, 0);
        chk("rst_cmds", {bus_if.o_regu_cmd, bus_if.o_prod_cmd, bus_if.o_actf_cmd}, 0);
        chk("rst_err",  bus_if.o_err, 0);
        chk("rst_bus",  {bus_if.o_cmd_op, bus_if.o_cmd_th, bus_if.o_cmd_pl}, 0);
        nrst = 1'b1;
        tick();

        // ---------------- single SETACC ----------------
        drive_cmd(OP_SETACC, 3'd3, 48'hABCD_0000_1010);
        tick();                                  // accept edge
        idle_cmd();
        chk("t1_disp_early", bus_if.o_regu_disp, 0);
        chk("t1_idle_busy",  bus_if.o_idle, 0);
        tick();                                  // issue edge
        chk("t1_disp",   bus_if.o_regu_disp, 1);
        chk("t1_op",     bus_if.o_cmd_op, OP_SETACC);
        chk("t1_th",     bus_if.o_cmd_th, 3);
        chk("t1_pl",     bus_if.o_cmd_pl, 48'hABCD_0000_1010);
        chk("t1_cmd",    bus_if.o_regu_cmd, 1);
        chk("t1_other",  {bus_if.o_prod_disp, bus_if.o_actf_disp}, 0);
        tick();
        chk("t1_disp_one", bus_if.o_regu_disp, 0);
        chk("t1_cmd_hold", bus_if.o_regu_cmd, 1);
        bus_if.i_regu_done = 1'b1;
        tick();                                  // done edge
        bus_if.i_regu_done = 1'b0;
        chk("t1_cmd_clr", bus_if.o_regu_cmd, 0);
        chk("t1_idle",    bus_if.o_idle, 1);

        // ---------------- back-to-back SETVL, SETVL, SETEN ----------------
        drive_cmd(OP_SETVL, 3'd0, 48'h1);
        tick();                                  // accept #1
        chk("t2_rdy_pass", bus_if.o_rdy, 1);
        drive_cmd(OP_SETVL, 3'd0, 48'h2);
        tick();                                  // issue #1, accept #2
        chk("t2_disp1", bus_if.o_regu_disp, 1);
        chk("t2_pl1",   bus_if.o_cmd_pl, 48'h1);
        chk("t2_rdy_full", bus_if.o_rdy, 0);
        drive_cmd(OP_SETEN, 3'd1, 48'h3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_wait_disp", bus_if.o_regu_disp, 0);
            chk("t2_wait_rdy",  bus_if.o_rdy, 0);
        end
        bus_if.i_regu_done = 1'b1;
        tick();                                  // done edge
        bus_if.i_regu_done = 1'b0;
        chk("t2_free_disp", bus_if.o_regu_disp, 0);
        chk("t2_free_rdy",  bus_if.o_rdy, 1);
        tick();                                  // issue #2, accept #3
        idle_cmd();
        chk("t2_disp2", bus_if.o_regu_disp, 1);
        chk("t2_op2",   bus_if.o_cmd_op, OP_SETVL);
        chk("t2_pl2",   bus_if.o_cmd_pl, 48'h2);
        chk("t2_rdy3",  bus_if.o_rdy, 0);
        bus_if.i_regu_done = 1'b1;
        tick();
        bus_if.i_regu_done = 1'b0;
        tick();                                  // issue #3
        chk("t2_disp3", bus_if.o_regu_disp, 1);
        chk("t2_op3",   bus_if.o_cmd_op, OP_SETEN);
        chk("t2_th3",   bus_if.o_cmd_th, 1);
        bus_if.i_regu_done = 1'b1;
        tick();
        bus_if.i_regu_done = 1'b0;
        chk("t2_idle", bus_if.o_idle, 1);

        // ---------------- PROD then SETRD, units overlap ----------------
        drive_cmd(OP_PROD, 3'd2, 48'h10);
        tick();
        drive_cmd(OP_SETRD, 3'd5, 48'h20);
        tick();
        idle_cmd();
        chk("t3_prod_disp", bus_if.o_prod_disp, 1);
        chk("t3_prod_op",   bus_if.o_cmd_op, OP_PROD);
        tick();
        chk("t3_regu_disp", bus_if.o_regu_disp, 1);
        chk("t3_regu_th",   bus_if.o_cmd_th, 5);
        chk("t3_both_cmd",  {bus_if.o_prod_cmd, bus_if.o_regu_cmd}, 2'b11);
        bus_if.i_prod_done = 1'b1;
        bus_if.i_regu_done = 1'b1;
        tick();
        bus_if.i_prod_done = 1'b0;
        bus_if.i_regu_done = 1'b0;
        chk("t3_idle", bus_if.o_idle, 1);

        // ---------------- PROD th4 then SETRS th4 ----------------
        drive_cmd(OP_PROD, 3'd4, 48'h30);
        tick();
        drive_cmd(OP_SETRS, 3'd4, 48'h40);
        tick();
        idle_cmd();
        chk("t4_prod_disp", bus_if.o_prod_disp, 1);
        tick();
`ifdef VXE_VPU_DISP_TH_HAZARD_EN
        chk("t4_hz_block",  bus_if.o_regu_disp, 0);
        tick();
        chk("t4_hz_block2", bus_if.o_regu_cmd, 0);
        bus_if.i_prod_done = 1'b1;
        tick();
        bus_if.i_prod_done = 1'b0;
        chk("t4_hz_still", bus_if.o_regu_disp, 0);
        tick();
        chk("t4_hz_disp", bus_if.o_regu_disp, 1);
        chk("t4_hz_op",   bus_if.o_cmd_op, OP_SETRS);
        bus_if.i_regu_done = 1'b1;
        tick();
        bus_if.i_regu_done = 1'b0;
`else
        chk("t4_nohz_disp", bus_if.o_regu_disp, 1);
        chk("t4_nohz_op",   bus_if.o_cmd_op, OP_SETRS);
        chk("t4_nohz_both", {bus_if.o_prod_cmd, bus_if.o_regu_cmd}, 2'b11);
        bus_if.i_prod_done = 1'b1;
        bus_if.i_regu_done = 1'b1;
        tick();
        bus_if.i_prod_done = 1'b0;
        bus_if.i_regu_done = 1'b0;
`endif
        chk("t4_idle", bus_if.o_idle, 1);

        // ---------------- unsupported opcode ----------------
        drive_cmd(OP_STORE, 3'd0, 48'h50);
        tick();
        idle_cmd();
        chk("t5_err_early", bus_if.o_err, 0);
        chk("t5_idle_busy", bus_if.o_idle, 0);
        tick();                                  // discard edge
        chk("t5_err",    bus_if.o_err, 1);
        chk("t5_nodisp", {bus_if.o_regu_disp, bus_if.o_prod_disp, bus_if.o_actf_disp}, 0);
        chk("t5_idle",   bus_if.o_idle, 1);
        chk("t5_bus",    bus_if.o_cmd_op, OP_SETRS);
        tick();
        chk("t5_err_one", bus_if.o_err, 0);

        // ---------------- reset while actf busy with hold full ----------------
        drive_cmd(OP_ACTF, 3'd6, 48'h60);
        tick();
        drive_cmd(OP_ACTF, 3'd7, 48'h70);
        tick();
        idle_cmd();
        chk("t6_actf_disp", bus_if.o_actf_disp, 1);
        chk("t6_rdy_full",  bus_if.o_rdy, 0);
        #2;
        nrst = 1'b0;
        #1;
        chk("t6_rst_rdy",  bus_if.o_rdy, 1);
        chk("t6_rst_idle", bus_if.o_idle, 1);
        chk("t6_rst_actf", {bus_if.o_actf_cmd, bus_if.o_actf_disp}, 0);
        chk("t6_rst_bus",  {bus_if.o_cmd_op, bus_if.o_cmd_th, bus_if.o_cmd_pl}, 0);
        tick();
        nrst = 1'b1;
        bus_if.i_actf_done = 1'b1;
        tick();
        bus_if.i_actf_done = 1'b0;
        chk("t6_late_cmd",  bus_if.o_actf_cmd, 0);
        chk("t6_late_idle", bus_if.o_idle, 1);
        tick();
        chk("t6_no_disp", bus_if.o_actf_disp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
